// File: rtl/rle_param_encoder.sv
// ---------------------------------------------------------------------------
// rle_param_encoder
//
// Parametrised run-length encoder working through port A of a shared
// dual-port SRAM. The engine reads the plaintext message word by word,
// scans it one byte per cycle and writes {symbol,count} pairs back. Two
// 16-bit pairs are packed per 32-bit word: the first pair goes in [15:0]
// and the second in [31:16]. Runs longer than MAX_RUN are split into
// several pairs. rle_size reports the exact compressed size in bytes.
//
// Optional feature (compile-time macro RLE_CYCLE_COUNT_EN):
//   When defined, an extra output cycle_count reports the number of clk
//   cycles from the accepted start to done rising, inclusive. When it is
//   not defined, the port and the counter do not exist.
//
// Ports:
//   clk              in   system clock, also forwarded to port_A_clk
//   reset            in   asynchronous, active-high reset
//   start            in   one-cycle pulse, only honoured while idle
//   message_addr     in   plaintext start byte address (word aligned)
//   message_size     in   plaintext length in bytes
//   rle_addr         in   output start byte address (word aligned)
//   rle_size         out  compressed length in bytes (2 * pairs)
//   done             out  high from job end until the next accepted start
//   port_A_clk       out  SRAM port A clock (= clk)
//   port_A_addr      out  SRAM byte address (read or write)
//   port_A_we        out  SRAM write enable
//   port_A_data_in   out  SRAM write data
//   port_A_data_out  in   SRAM read data, one cycle after the address
//   cycle_count      out  job cycle counter (only with RLE_CYCLE_COUNT_EN)
// ---------------------------------------------------------------------------
module rle_param_encoder #(
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 16,
    parameter int MAX_RUN = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       message_size,
    input  logic [31:0]       rle_addr,
    output logic [31:0]       rle_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
`ifdef RLE_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_SCAN    = 3'd3;
    localparam logic [2:0] ST_WRITE   = 3'd4;
    localparam logic [2:0] ST_FLUSH   = 3'd5;
    localparam logic [2:0] ST_FIN     = 3'd6;

    localparam logic [7:0]        LP_MAX_RUN  = 8'(MAX_RUN);
    localparam logic [ADDR_W-1:0] LP_WORD     = {{(ADDR_W-3){1'b0}}, 3'b100};
    localparam logic [LEN_W-1:0]  LP_ONE_LEN  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W:0]    LP_ONE_PAIR = {{LEN_W{1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_rdAddr;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [LEN_W-1:0]  r_remain;
    logic [31:0]       r_shift;
    logic [1:0]        r_byteIdx;
    logic              r_first;
    logic [7:0]        r_sym;
    logic [7:0]        r_cnt;
    logic [15:0]       r_buf;
    logic              r_bufValid;
    logic [31:0]       r_wrData;
    logic [LEN_W:0]    r_pairs;

    logic [7:0]  w_byte;
    logic        w_extend;
    logic        w_emit;
    logic        w_lastByte;
    logic [15:0] w_pair;
    logic [31:0] w_flushWord;
    logic        w_unused;

    assign port_A_clk = clk;

    // Scan datapath: the byte under inspection is always the low byte of the
    // shift register. A run is extended only while it matches and has room.
    assign w_byte     = r_shift[7:0];
    assign w_extend   = (w_byte == r_sym) && (r_cnt < LP_MAX_RUN);
    assign w_emit     = !r_first && !w_extend;
    assign w_lastByte = (r_remain == LP_ONE_LEN);
    assign w_pair     = {r_sym, r_cnt};

    // The final open run lands in the high half if a pair is already
    // buffered in the low half, otherwise it goes alone in the low half.
    assign w_flushWord = r_bufValid ? {w_pair, r_buf} : {16'h0000, w_pair};

    // Port A is driven directly from state so that a write and a read can
    // never coincide: only WRITE and FLUSH assert the write enable.
    assign port_A_we      = (r_state == ST_WRITE) || (r_state == ST_FLUSH);
    assign port_A_data_in = (r_state == ST_FLUSH) ? w_flushWord : r_wrData;
    assign port_A_addr    = port_A_we ? r_wrAddr : r_rdAddr;

    // Only the low ADDR_W / LEN_W bits of the wide inputs matter.
    assign w_unused = ^{message_addr, message_size, rle_addr};

    // Main controller: fetch a word, scan its bytes one per cycle, emit
    // packed pair words as they fill and flush the last run at the end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rdAddr   <= '0;
            r_wrAddr   <= '0;
            r_remain   <= '0;
            r_shift    <= '0;
            r_byteIdx  <= '0;
            r_first    <= 1'b1;
            r_sym      <= '0;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_bufValid <= 1'b0;
            r_wrData   <= '0;
            r_pairs    <= '0;
            rle_size   <= '0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rdAddr   <= message_addr[ADDR_W-1:0];
                        r_wrAddr   <= rle_addr[ADDR_W-1:0];
                        r_remain   <= message_size[LEN_W-1:0];
                        r_byteIdx  <= '0;
                        r_first    <= 1'b1;
                        r_bufValid <= 1'b0;
                        r_pairs    <= '0;
                        rle_size   <= '0;
                        done       <= 1'b0;
                        if (message_size[LEN_W-1:0] == '0) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_state <= ST_RD_REQ;
                        end
                    end
                end

                ST_RD_REQ: begin
                    r_rdAddr <= r_rdAddr + LP_WORD;
                    r_state  <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    r_shift <= port_A_data_out;
                    r_state <= ST_SCAN;
                end

                ST_SCAN: begin
                    r_shift   <= {8'h00, r_shift[31:8]};
                    r_byteIdx <= r_byteIdx + 2'd1;
                    r_remain  <= r_remain - LP_ONE_LEN;
                    r_first   <= 1'b0;
                    if (r_first || !w_extend) begin
                        r_sym <= w_byte;
                        r_cnt <= 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (w_emit) begin
                        r_pairs <= r_pairs + LP_ONE_PAIR;
                        if (r_bufValid) begin
                            r_wrData   <= {w_pair, r_buf};
                            r_bufValid <= 1'b0;
                        end else begin
                            r_buf      <= w_pair;
                            r_bufValid <= 1'b1;
                        end
                    end
                    // A completed word has priority; WRITE itself then
                    // decides between more scanning, a fetch or the flush.
                    if (w_emit && r_bufValid) begin
                        r_state <= ST_WRITE;
                    end else if (w_lastByte) begin
                        r_state <= ST_FLUSH;
                    end else if (r_byteIdx == 2'd3) begin
                        r_state <= ST_RD_REQ;
                    end
                end

                ST_WRITE: begin
                    r_wrAddr <= r_wrAddr + LP_WORD;
                    if (r_remain == '0) begin
                        r_state <= ST_FLUSH;
                    end else if (r_byteIdx == 2'd0) begin
                        r_state <= ST_RD_REQ;
                    end else begin
                        r_state <= ST_SCAN;
                    end
                end

                ST_FLUSH: begin
                    r_pairs    <= r_pairs + LP_ONE_PAIR;
                    r_wrAddr   <= r_wrAddr + LP_WORD;
                    r_bufValid <= 1'b0;
                    r_state    <= ST_FIN;
                end

                ST_FIN: begin
                    rle_size <= 32'({r_pairs, 1'b0});
                    done     <= 1'b1;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RLE_CYCLE_COUNT_EN
    logic [31:0] r_cycleCount;

    // Counts the accepting cycle as 1 and every busy cycle up to and
    // including FIN, then holds until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycleCount <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_cycleCount <= 32'd1;
        end else if (r_state != ST_IDLE) begin
            r_cycleCount <= r_cycleCount + 32'd1;
        end
    end

    assign cycle_count = r_cycleCount;
`endif

endmodule
